// File: rtl/show_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : show_pkg
// Brief    : Shared constants and FSM state type for show_bcd_packer.
//            Optional feature macro: LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package show_pkg;

  localparam int DIGITS  = 8;
  localparam int VALUE_W = 27;
  localparam int ACC_W   = DIGITS * 4;
  localparam int CNT_W   = $clog2(VALUE_W + 1);

  localparam logic [VALUE_W-1:0] SAT_MAX    = 27'd99_999_999;
  localparam logic [3:0]         BLANK_CODE = 4'hF;
  localparam logic [ACC_W-1:0]   SAT_SHOW   = 32'h9999_9999;
  // Counter value seen on the edge that performs the final shift.
  localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(VALUE_W - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/show_bcd_packer_bcd_digit_adj.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : bcd_digit_adj
// Brief    : Double-dabble digit corrector: add 3 when the digit is >= 5.
//            Optional feature macro: LEADING_ZERO_BLANK_EN (not used here).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // No carry out: a valid digit is at most 9, so the result is at most 12.
  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/show_bcd_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : show_bcd_packer
// Brief    : Serial binary-to-packed-BCD converter feeding the 8-digit display.
//            Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module show_bcd_packer
  import show_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  output logic [ACC_W-1:0]   show,
  output logic               busy,
  output logic               done,
  output logic               ovf
);

  state_t               r_state;
  state_t               w_state_next;
  logic [VALUE_W-1:0]   r_sreg;
  logic [ACC_W-1:0]     r_acc;
  logic [ACC_W-1:0]     w_acc_adj;
  logic [ACC_W-1:0]     w_acc_next;
  logic [ACC_W-1:0]     w_result;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sat;
  logic [ACC_W-1:0]     r_show;
  logic                 r_done;
  logic                 r_ovf;
  logic                 w_accept;
  logic                 w_last;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_adj u_adj (
        .i_digit (r_acc[4*gi +: 4]),
        .o_digit (w_acc_adj[4*gi +: 4])
      );
    end
  endgenerate

  assign w_acc_next = {w_acc_adj[ACC_W-2:0], r_sreg[VALUE_W-1]};

`ifdef LEADING_ZERO_BLANK_EN
  // Walk down from the top digit, blanking zeros until the first non-zero one.
  function automatic logic [ACC_W-1:0] blank_leading(input logic [ACC_W-1:0] bcd);
    logic [ACC_W-1:0] res;
    logic             lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && (bcd[4*i +: 4] == 4'h0)) begin
        res[4*i +: 4] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

  assign w_result = blank_leading(w_acc_next);
`else
  assign w_result = w_acc_next;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sreg <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_sat  <= 1'b0;
      r_show <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sreg <= in_value;
        r_acc  <= '0;
        r_cnt  <= '0;
        r_sat  <= (in_value > SAT_MAX);
      end else if (r_state == ST_SHIFT) begin
        r_acc  <= w_acc_next;
        r_sreg <= {r_sreg[VALUE_W-2:0], 1'b0};
        r_cnt  <= r_cnt + CNT_W'(1);
        // A saturated result keeps all nines and is never blanked.
        if (w_last) begin
          r_show <= r_sat ? SAT_SHOW : w_result;
          r_ovf  <= r_sat;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign in_ready = (r_state == ST_IDLE);
  assign busy     = (r_state == ST_SHIFT);
  assign show     = r_show;
  assign done     = r_done;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_show_bcd_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_show_bcd_packer
// Brief    : Self-checking bench for show_bcd_packer against a decimal model.
//            Optional feature macro: LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_show_bcd_packer;

  logic        clk      = 1'b0;
  logic        rstn     = 1'b1;
  logic        in_valid = 1'b0;
  logic [26:0] in_value = '0;
  logic        in_ready;
  logic [31:0] show;
  logic        busy;
  logic        done;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  show_bcd_packer dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .show     (show),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits from plain division; all nines above the saturation limit.
  function automatic logic [31:0] ref_show(input int unsigned v);
    logic [31:0] r;
    int unsigned t;
    int unsigned p;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    p = 1;
    for (int i = 1; i < 8; i++) begin
      p = p * 10;
      if (v < p) r[4*i +: 4] = 4'hF;
    end
`else
    p = 0;
`endif
    return r;
  endfunction

  // Transaction-level model: accept -> 27 edges -> result.
  bit          m_busy = 1'b0;
  int          m_left = 0;
  int unsigned m_val  = 0;
  logic [31:0] m_show = '0;
  bit          m_ovf  = 1'b0;
  bit          m_done = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy = 1'b0;
      m_left = 0;
      m_show = '0;
      m_ovf  = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_show = ref_show(m_val);
          m_ovf  = (m_val > 32'd99_999_999);
          m_done = 1'b1;
        end
      end else if (in_valid) begin
        m_busy = 1'b1;
        m_left = 27;
        m_val  = in_value;
      end
    end
  end

  int cyc      = 0;
  int acc_cnt  = 0;
  int last_acc = 0;
  int ndone    = 0;

  always @(posedge clk) begin
    cyc++;
    if (rstn && in_valid && in_ready) begin
      acc_cnt++;
      last_acc = cyc;
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
    check("cyc_busy",     {31'b0, busy},     {31'b0, m_busy});
    check("cyc_done",     {31'b0, done},     {31'b0, m_done});
    check("cyc_ovf",      {31'b0, ovf},      {31'b0, m_ovf});
    check("cyc_show",     show,              m_show);
    if (done) ndone++;
  end

  task automatic start(input logic [26:0] v);
    int a0;
    bit ok;
    a0 = acc_cnt;
    ok = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_value = v;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      if (acc_cnt != a0) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Runs one conversion; show must hold its old value until done.
  task automatic convert(input logic [26:0] v, input logic [31:0] exp, input logic exp_ovf);
    logic [31:0] prev;
    int          nb;
    bit          ok;
    prev = show;
    nb   = 0;
    ok   = 1'b0;
    start(v);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
      if (busy) nb++;
      check("hold_show", show, prev);
    end
    if (!ok) check("done_timeout", 32'd0, 32'd1);
    check("conv_show",    show, exp);
    check("conv_ovf",     {31'b0, ovf}, {31'b0, exp_ovf});
    check("conv_latency", cyc - last_acc, 32'd27);
    check("conv_busy",    nb, 32'd27);
  endtask

  function automatic logic [26:0] pick();
    case ($urandom_range(0, 5))
      0:       return 27'($urandom_range(0, 99));
      1:       return 27'd99_999_999;
      2:       return 27'd100_000_000;
      3:       return 27'($urandom_range(100_000_001, 134_217_727));
      default: return 27'($urandom_range(0, 99_999_999));
    endcase
  endfunction

  initial begin
    int a1;
    int dn;
    bit ok;
    #1 rstn = 1'b0;
    #1;
    check("rst_show",     show, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_busy",     {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;

`ifdef LEADING_ZERO_BLANK_EN
    convert(27'd12_345_678,  32'h1234_5678, 1'b0);
    convert(27'd99_999_999,  32'h9999_9999, 1'b0);
    convert(27'd100_000_000, 32'h9999_9999, 1'b1);
    convert(27'd7,           32'hFFFF_FFF7, 1'b0);
    convert(27'd0,           32'hFFFF_FFF0, 1'b0);
    convert(27'd42,          32'hFFFF_FF42, 1'b0);
    convert(27'd1,           32'hFFFF_FFF1, 1'b0);
`else
    convert(27'd12_345_678,  32'h1234_5678, 1'b0);
    convert(27'd99_999_999,  32'h9999_9999, 1'b0);
    convert(27'd100_000_000, 32'h9999_9999, 1'b1);
    convert(27'd7,           32'h0000_0007, 1'b0);
    convert(27'd0,           32'h0000_0000, 1'b0);
    convert(27'd42,          32'h0000_0042, 1'b0);
    convert(27'd1,           32'h0000_0001, 1'b0);
`endif
    convert(27'd55_555_555,  32'h5555_5555, 1'b0);

    // Value held valid during a conversion is taken only on return to idle.
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_value = 27'd3_600;
    @(posedge clk); #2;
    a1 = last_acc;
    in_value = 27'd5;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    check("b2b_first_done", {31'b0, ok}, 32'd1);
`ifdef LEADING_ZERO_BLANK_EN
    check("b2b_first_show", show, 32'hFFFF_3600);
`else
    check("b2b_first_show", show, 32'h0000_3600);
`endif
    @(posedge clk); #2;
    in_valid = 1'b0;
    check("b2b_accept_gap", last_acc - a1, 32'd28);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    check("b2b_second_done", {31'b0, ok}, 32'd1);
`ifdef LEADING_ZERO_BLANK_EN
    check("b2b_second_show", show, 32'hFFFF_FFF5);
`else
    check("b2b_second_show", show, 32'h0000_0005);
`endif

    // Reset in the middle of a conversion aborts it silently.
    start(27'd12_345_678);
    repeat (9) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("abort_show",     show, 32'h0);
    check("abort_busy",     {31'b0, busy}, 32'd0);
    check("abort_done",     {31'b0, done}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    dn = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort_no_done",  dn, 32'd0);
    check("abort_ready_up", {31'b0, in_ready}, 32'd1);

    // Random traffic, including values changing while busy.
    dn = ndone;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      in_valid = ($urandom_range(0, 3) != 0);
      in_value = pick();
    end
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    check("rand_conversions", {31'b0, (ndone - dn) >= 50}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
